// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM command responder and the DRAM controller:
// command opcodes, error-bit positions, refresh FSM states and width helpers.
package dram_pkg;

    localparam logic [2:0] CMD_REF = 3'b000;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_NOP = 3'b111;

    localparam int ERR_ACT_OPEN      = 0;
    localparam int ERR_CLOSED_ACCESS = 1;
    localparam int ERR_REF_OPEN      = 2;
    localparam int ERR_ILLEGAL       = 3;
    localparam int ERR_RETENTION     = 4;
    localparam int ERR_WIDTH         = 5;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_BUSY = 2'd1,
        R_DONE = 2'd2
    } refresh_state_t;

    function automatic int dram_col_width(input int columns, input int data_width);
        return $clog2(columns / data_width);
    endfunction

    function automatic int dram_row_width(input int rows);
        return $clog2(rows);
    endfunction

    function automatic int dram_bank_width(input int banks);
        return $clog2(banks);
    endfunction

    // The address bus carries either a row or a column, so it is as wide as the larger.
    function automatic int dram_addr_width(input int rows, input int columns, input int data_width);
        int row_w;
        int col_w;
        row_w = dram_row_width(rows);
        col_w = dram_col_width(columns, data_width);
        return (row_w > col_w) ? row_w : col_w;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Refresh sequencer for the DRAM responder: IDLE/BUSY/DONE FSM with countdown.
// Optional retention watchdog enabled by DRAM_CMD_RESPONDER_RETENTION_EN.
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int REFRESH_CYCLES   = 4,
    parameter int RETENTION_CYCLES = 12500
) (
    input  logic u_clk,
    input  logic u_rst_n,
    input  logic clk_en,
    input  logic ref_req,
    output logic busy,
    output logic refresh_done,
    output logic data_lost,
    output logic retention_err
);

    localparam int CNT_WIDTH = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    refresh_state_t       state_q;
    refresh_state_t       state_d;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic                 done_d;

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            state_q      <= R_IDLE;
            count_q      <= '0;
            refresh_done <= 1'b0;
        end else if (clk_en) begin
            state_q      <= state_d;
            count_q      <= count_d;
            refresh_done <= done_d;
        end
    end

    // Loading REFRESH_CYCLES-1 and leaving BUSY on the zero edge lands DONE
    // exactly REFRESH_CYCLES enabled edges after acceptance.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            R_IDLE: begin
                if (ref_req) begin
                    state_d = R_BUSY;
                    count_d = CNT_WIDTH'(REFRESH_CYCLES - 1);
                end
            end
            R_BUSY: begin
                if (count_q == '0) begin
                    state_d = R_DONE;
                end else begin
                    count_d = count_q - CNT_WIDTH'(1);
                end
            end
            R_DONE:  state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
        done_d = (state_d == R_DONE);
    end

    assign busy = (state_q != R_IDLE);

`ifdef DRAM_CMD_RESPONDER_RETENTION_EN
    localparam int RET_WIDTH = $clog2(RETENTION_CYCLES + 1);

    logic [RET_WIDTH-1:0] ret_count_q;
    logic                 lost_q;

    // Saturating age counter; data stays lost until a refresh completes.
    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            ret_count_q <= '0;
            lost_q      <= 1'b0;
        end else if (clk_en) begin
            if (refresh_done) begin
                ret_count_q <= '0;
                lost_q      <= 1'b0;
            end else if (ret_count_q == RET_WIDTH'(RETENTION_CYCLES)) begin
                lost_q <= 1'b1;
            end else begin
                ret_count_q <= ret_count_q + RET_WIDTH'(1);
            end
        end
    end

    assign data_lost     = lost_q;
    assign retention_err = lost_q;
`else
    localparam int unused_retention_cycles = RETENTION_CYCLES;

    assign data_lost     = 1'b0;
    assign retention_err = 1'b0;
`endif

endmodule

// File: rtl/dram_cmd_responder.sv
// DRAM device model: decodes the command bus, tracks open rows, stores data and
// returns reads after CAS_LATENCY. Optional retention check: DRAM_CMD_RESPONDER_RETENTION_EN.
module dram_cmd_responder
    import dram_pkg::*;
#(
    parameter int NUMBER_OF_COLUMNS = 8,
    parameter int NUMBER_OF_ROWS    = 128,
    parameter int NUMBER_OF_BANKS   = 8,
    parameter int DRAM_DATA_WIDTH   = 2,
    parameter int CAS_LATENCY       = 1,
    parameter int REFRESH_CYCLES    = 4,
    parameter int RETENTION_CYCLES  = 12500,
    localparam int COLUMN_WIDTH     = dram_col_width(NUMBER_OF_COLUMNS, DRAM_DATA_WIDTH),
    localparam int ROW_WIDTH        = dram_row_width(NUMBER_OF_ROWS),
    localparam int BANK_ID_WIDTH    = dram_bank_width(NUMBER_OF_BANKS),
    localparam int DRAM_ADDR_WIDTH  = dram_addr_width(NUMBER_OF_ROWS, NUMBER_OF_COLUMNS, DRAM_DATA_WIDTH)
) (
    input  logic                       u_clk,
    input  logic                       u_rst_n,
    input  logic                       dram_clk_en,
    input  logic                       dram_cs_n,
    input  logic                       dram_ras_n,
    input  logic                       dram_cas_n,
    input  logic                       dram_we_n,
    input  logic [BANK_ID_WIDTH-1:0]   dram_bank_id,
    input  logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
    input  logic [DRAM_DATA_WIDTH-1:0] dram_wr_data,
    output logic [DRAM_DATA_WIDTH-1:0] dram_rd_data,
    output logic                       dram_refresh_done,
    output logic [NUMBER_OF_BANKS-1:0] bank_open_o,
    output logic [ERR_WIDTH-1:0]       err_flags_o
);

    localparam int WORDS_PER_ROW   = NUMBER_OF_COLUMNS / DRAM_DATA_WIDTH;
    localparam int MEM_DEPTH       = NUMBER_OF_BANKS * NUMBER_OF_ROWS * WORDS_PER_ROW;
    localparam int MEM_INDEX_WIDTH = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH;

    logic [DRAM_DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [NUMBER_OF_BANKS-1:0] bank_open_q;
    logic [ROW_WIDTH-1:0]       active_row_q [NUMBER_OF_BANKS];
    logic [ERR_WIDTH-1:0]       err_q;
    logic [CAS_LATENCY-1:0]     pipe_valid_q;
    logic [DRAM_DATA_WIDTH-1:0] pipe_data_q [CAS_LATENCY];

    logic                       cmd_valid;
    logic [2:0]                 cmd;
    logic [COLUMN_WIDTH-1:0]    col;
    logic [ROW_WIDTH-1:0]       row;
    logic [MEM_INDEX_WIDTH-1:0] mem_index;
    logic                       bank_is_open;
    logic [DRAM_DATA_WIDTH-1:0] rd_word;
    logic                       refresh_busy;
    logic                       data_lost;
    logic                       retention_err;
    logic                       ref_req;
    logic                       do_pre;
    logic                       do_act;
    logic                       do_wr;
    logic                       do_rd;
    logic [ERR_WIDTH-1:0]       err_set;

    assign cmd_valid    = dram_clk_en && !dram_cs_n;
    assign cmd          = {dram_ras_n, dram_cas_n, dram_we_n};
    assign col          = dram_addr[COLUMN_WIDTH-1:0];
    assign row          = dram_addr[ROW_WIDTH-1:0];
    assign bank_is_open = bank_open_q[dram_bank_id];
    assign mem_index    = {dram_bank_id, active_row_q[dram_bank_id], col};
    assign rd_word      = (bank_is_open && !data_lost) ? mem[mem_index] : '0;

    dram_refresh_timer #(
        .REFRESH_CYCLES   (REFRESH_CYCLES),
        .RETENTION_CYCLES (RETENTION_CYCLES)
    ) u_refresh_timer (
        .u_clk         (u_clk),
        .u_rst_n       (u_rst_n),
        .clk_en        (dram_clk_en),
        .ref_req       (ref_req),
        .busy          (refresh_busy),
        .refresh_done  (dram_refresh_done),
        .data_lost     (data_lost),
        .retention_err (retention_err)
    );

    // Bank commands are rejected while a refresh owns the device; REFRESH itself
    // is absorbed by the timer when one is already in flight.
    always_comb begin
        do_pre  = 1'b0;
        do_act  = 1'b0;
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        ref_req = 1'b0;
        err_set = '0;
        if (cmd_valid) begin
            case (cmd)
                CMD_REF: begin
                    ref_req = 1'b1;
                    if (!refresh_busy && (|bank_open_q)) begin
                        err_set[ERR_REF_OPEN] = 1'b1;
                    end
                end
                CMD_NOP: ;
                CMD_PRE, CMD_ACT, CMD_WR, CMD_RD: begin
                    if (refresh_busy) begin
                        err_set[ERR_ILLEGAL] = 1'b1;
                    end else begin
                        case (cmd)
                            CMD_PRE: do_pre = 1'b1;
                            CMD_ACT: begin
                                if (bank_is_open) err_set[ERR_ACT_OPEN] = 1'b1;
                                else              do_act = 1'b1;
                            end
                            CMD_WR: begin
                                if (bank_is_open) do_wr = 1'b1;
                                else              err_set[ERR_CLOSED_ACCESS] = 1'b1;
                            end
                            default: begin
                                do_rd = 1'b1;
                                if (!bank_is_open) err_set[ERR_CLOSED_ACCESS] = 1'b1;
                            end
                        endcase
                    end
                end
                default: err_set[ERR_ILLEGAL] = 1'b1;
            endcase
        end
        err_set[ERR_RETENTION] = retention_err;
    end

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            bank_open_q  <= '0;
            err_q        <= '0;
            pipe_valid_q <= '0;
            dram_rd_data <= '0;
            for (int i = 0; i < NUMBER_OF_BANKS; i++) begin
                active_row_q[i] <= '0;
            end
            for (int i = 0; i < CAS_LATENCY; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else if (dram_clk_en) begin
            err_q <= err_q | err_set;
            if (do_pre) begin
                bank_open_q[dram_bank_id] <= 1'b0;
            end
            if (do_act) begin
                bank_open_q[dram_bank_id]  <= 1'b1;
                active_row_q[dram_bank_id] <= row;
            end
            pipe_valid_q[0] <= do_rd;
            pipe_data_q[0]  <= rd_word;
            for (int i = 1; i < CAS_LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_data_q[i]  <= pipe_data_q[i-1];
            end
            if (pipe_valid_q[CAS_LATENCY-1]) begin
                dram_rd_data <= pipe_data_q[CAS_LATENCY-1];
            end
        end
    end

    // Array contents survive reset, as a real device's cells would.
    always_ff @(posedge u_clk) begin
        if (do_wr) begin
            mem[mem_index] <= dram_wr_data;
        end
    end

    assign bank_open_o = bank_open_q;
    assign err_flags_o = err_q;

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Self-checking bench for dram_cmd_responder: CAS latency 1 and 3 instances share
// one command bus; read data is scoreboarded, bank/error state is table-checked.
module tb_dram_cmd_responder;
    import dram_pkg::*;

    localparam int CL_A = 1;
    localparam int CL_B = 3;
    localparam logic [2:0] CMD_ILL1 = 3'b001;
    localparam logic [2:0] CMD_ILL2 = 3'b110;

    logic       u_clk = 1'b0;
    logic       u_rst_n;
    logic       dram_clk_en;
    logic       dram_cs_n;
    logic       dram_ras_n;
    logic       dram_cas_n;
    logic       dram_we_n;
    logic [2:0] dram_bank_id;
    logic [6:0] dram_addr;
    logic [1:0] dram_wr_data;
    logic [1:0] rd_data_a;
    logic [1:0] rd_data_b;
    logic       done_a;
    logic       done_b;
    logic [7:0] open_a;
    logic [7:0] open_b;
    logic [4:0] err_a;
    logic [4:0] err_b;

    always #5 u_clk = ~u_clk;

    dram_cmd_responder #(.CAS_LATENCY(CL_A)) dut (
        .u_clk(u_clk), .u_rst_n(u_rst_n), .dram_clk_en(dram_clk_en),
        .dram_cs_n(dram_cs_n), .dram_ras_n(dram_ras_n), .dram_cas_n(dram_cas_n),
        .dram_we_n(dram_we_n), .dram_bank_id(dram_bank_id), .dram_addr(dram_addr),
        .dram_wr_data(dram_wr_data), .dram_rd_data(rd_data_a),
        .dram_refresh_done(done_a), .bank_open_o(open_a), .err_flags_o(err_a)
    );

    dram_cmd_responder #(.CAS_LATENCY(CL_B)) dut_cl3 (
        .u_clk(u_clk), .u_rst_n(u_rst_n), .dram_clk_en(dram_clk_en),
        .dram_cs_n(dram_cs_n), .dram_ras_n(dram_ras_n), .dram_cas_n(dram_cas_n),
        .dram_we_n(dram_we_n), .dram_bank_id(dram_bank_id), .dram_addr(dram_addr),
        .dram_wr_data(dram_wr_data), .dram_rd_data(rd_data_b),
        .dram_refresh_done(done_b), .bank_open_o(open_b), .err_flags_o(err_b)
    );

    typedef struct {
        logic [1:0] data;
        int         due;
    } sb_entry_t;

    typedef struct {
        logic [2:0] cmd;
        logic [2:0] bank;
        logic [6:0] addr;
        logic [1:0] wdata;
        logic [1:0] exp_rd;
        logic [7:0] exp_open;
        logic [4:0] exp_err;
    } vec_t;

    sb_entry_t sb_a[$];
    sb_entry_t sb_b[$];
    vec_t      vecs[$];
    int        en_edges = 0;
    int        n_checks = 0;
    int        n_fails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it and due reads retired.
    task automatic tick();
        sb_entry_t e;
        @(posedge u_clk);
        if (dram_clk_en) en_edges++;
        #1;
        while (sb_a.size() > 0 && sb_a[0].due <= en_edges) begin
            e = sb_a.pop_front();
            checkOutput("rd_data_cl1", {30'd0, rd_data_a}, {30'd0, e.data});
        end
        while (sb_b.size() > 0 && sb_b[0].due <= en_edges) begin
            e = sb_b.pop_front();
            checkOutput("rd_data_cl3", {30'd0, rd_data_b}, {30'd0, e.data});
        end
    endtask

    task automatic applyStimulus(input logic [2:0] cmd, input logic [2:0] bank,
                                 input logic [6:0] addr, input logic [1:0] wdata,
                                 input logic [1:0] exp_rd);
        sb_entry_t e;
        dram_cs_n = 1'b0;
        {dram_ras_n, dram_cas_n, dram_we_n} = cmd;
        dram_bank_id = bank;
        dram_addr    = addr;
        dram_wr_data = wdata;
        if (dram_clk_en && cmd == CMD_RD) begin
            e.data = exp_rd;
            e.due  = en_edges + 1 + CL_A;
            sb_a.push_back(e);
            e.due  = en_edges + 1 + CL_B;
            sb_b.push_back(e);
        end
        tick();
    endtask

    task automatic idleBus();
        dram_cs_n = 1'b1;
        {dram_ras_n, dram_cas_n, dram_we_n} = CMD_NOP;
        dram_bank_id = '0;
        dram_addr    = '0;
        dram_wr_data = '0;
    endtask

    task automatic doReset();
        @(negedge u_clk);
        idleBus();
        u_rst_n = 1'b0;
        sb_a.delete();
        sb_b.delete();
        @(negedge u_clk);
        u_rst_n = 1'b1;
        tick();
    endtask

    task automatic addVec(input logic [2:0] cmd, input logic [2:0] bank, input logic [6:0] addr,
                          input logic [1:0] wdata, input logic [1:0] exp_rd,
                          input logic [7:0] exp_open, input logic [4:0] exp_err);
        vec_t v;
        v = '{cmd, bank, addr, wdata, exp_rd, exp_open, exp_err};
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        u_rst_n     = 1'b1;
        dram_clk_en = 1'b1;
        idleBus();

        addVec(CMD_ACT, 3'd3, 7'h45, 2'b00, 2'b00, 8'h08, 5'h00);
        addVec(CMD_WR,  3'd3, 7'd2,  2'b10, 2'b00, 8'h08, 5'h00);
        addVec(CMD_WR,  3'd3, 7'd0,  2'b01, 2'b00, 8'h08, 5'h00);
        addVec(CMD_WR,  3'd3, 7'd1,  2'b11, 2'b00, 8'h08, 5'h00);
        addVec(CMD_RD,  3'd3, 7'd2,  2'b00, 2'b10, 8'h08, 5'h00);
        addVec(CMD_RD,  3'd3, 7'd0,  2'b00, 2'b01, 8'h08, 5'h00);
        addVec(CMD_RD,  3'd3, 7'd1,  2'b00, 2'b11, 8'h08, 5'h00);
        addVec(CMD_NOP, 3'd0, 7'd0,  2'b00, 2'b00, 8'h08, 5'h00);
        addVec(CMD_NOP, 3'd0, 7'd0,  2'b00, 2'b00, 8'h08, 5'h00);
        addVec(CMD_NOP, 3'd0, 7'd0,  2'b00, 2'b00, 8'h08, 5'h00);
        addVec(CMD_PRE, 3'd3, 7'd0,  2'b00, 2'b00, 8'h00, 5'h00);
        addVec(CMD_PRE, 3'd3, 7'd0,  2'b00, 2'b00, 8'h00, 5'h00);
        addVec(CMD_ACT, 3'd3, 7'h12, 2'b00, 2'b00, 8'h08, 5'h00);
        addVec(CMD_WR,  3'd3, 7'd2,  2'b01, 2'b00, 8'h08, 5'h00);
        addVec(CMD_RD,  3'd3, 7'd2,  2'b00, 2'b01, 8'h08, 5'h00);
        addVec(CMD_PRE, 3'd3, 7'd0,  2'b00, 2'b00, 8'h00, 5'h00);
        addVec(CMD_ACT, 3'd3, 7'h45, 2'b00, 2'b00, 8'h08, 5'h00);
        addVec(CMD_RD,  3'd3, 7'd2,  2'b00, 2'b10, 8'h08, 5'h00);
        addVec(CMD_RD,  3'd5, 7'd3,  2'b00, 2'b00, 8'h08, 5'h02);
        addVec(CMD_ACT, 3'd5, 7'h21, 2'b00, 2'b00, 8'h28, 5'h02);
        addVec(CMD_WR,  3'd5, 7'd3,  2'b10, 2'b00, 8'h28, 5'h02);
        addVec(CMD_ACT, 3'd5, 7'h33, 2'b00, 2'b00, 8'h28, 5'h03);
        addVec(CMD_RD,  3'd5, 7'd3,  2'b00, 2'b10, 8'h28, 5'h03);
        addVec(CMD_ILL1, 3'd0, 7'd0, 2'b00, 2'b00, 8'h28, 5'h0B);
        addVec(CMD_PRE, 3'd3, 7'd0,  2'b00, 2'b00, 8'h20, 5'h0B);
        addVec(CMD_PRE, 3'd5, 7'd0,  2'b00, 2'b00, 8'h00, 5'h0B);
        addVec(CMD_NOP, 3'd0, 7'd0,  2'b00, 2'b00, 8'h00, 5'h0B);
        addVec(CMD_NOP, 3'd0, 7'd0,  2'b00, 2'b00, 8'h00, 5'h0B);
        addVec(CMD_NOP, 3'd0, 7'd0,  2'b00, 2'b00, 8'h00, 5'h0B);

        #1 u_rst_n = 1'b0;
        #2;
        checkOutput("reset rd_data", {30'd0, rd_data_a}, 32'd0);
        checkOutput("reset done", {31'd0, done_a}, 32'd0);
        checkOutput("reset bank_open", {24'd0, open_a}, 32'd0);
        checkOutput("reset err_flags", {27'd0, err_a}, 32'd0);
        doReset();

        $display("[TB] table-driven command vectors");
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].cmd, vecs[i].bank, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
            checkOutput($sformatf("vec%0d bank_open", i), {24'd0, open_a}, {24'd0, vecs[i].exp_open});
            checkOutput($sformatf("vec%0d err_flags", i), {27'd0, err_a}, {27'd0, vecs[i].exp_err});
        end
        checkOutput("scoreboard cl1 drained", sb_a.size(), 32'd0);
        checkOutput("scoreboard cl3 drained", sb_b.size(), 32'd0);

        $display("[TB] refresh with bank 0 open");
        doReset();
        applyStimulus(CMD_ACT, 3'd0, 7'd1, 2'b00, 2'b00);
        applyStimulus(CMD_REF, 3'd0, 7'd0, 2'b00, 2'b00);
        checkOutput("ref accept err_flags", {27'd0, err_a}, 32'h04);
        checkOutput("ref accept done", {31'd0, done_a}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus((k <= 4) ? CMD_REF : CMD_NOP, 3'd0, 7'd0, 2'b00, 2'b00);
            checkOutput($sformatf("ref done edge%0d", k), {31'd0, done_a}, {31'd0, (k == 4)});
        end
        checkOutput("ref bank_open kept", {24'd0, open_a}, 32'h01);
        checkOutput("ref err_flags", {27'd0, err_a}, 32'h04);

        $display("[TB] bank command during refresh");
        applyStimulus(CMD_REF, 3'd0, 7'd0, 2'b00, 2'b00);
        applyStimulus(CMD_ACT, 3'd2, 7'd9, 2'b00, 2'b00);
        checkOutput("busy act err_flags", {27'd0, err_a}, 32'h0C);
        checkOutput("busy act bank_open", {24'd0, open_a}, 32'h01);
        for (int k = 2; k <= 5; k++) begin
            applyStimulus((k <= 4) ? CMD_REF : CMD_NOP, 3'd0, 7'd0, 2'b00, 2'b00);
            checkOutput($sformatf("busy act done edge%0d", k), {31'd0, done_a}, {31'd0, (k == 4)});
        end

        $display("[TB] clock-enable freeze during refresh");
        doReset();
        applyStimulus(CMD_REF, 3'd0, 7'd0, 2'b00, 2'b00);
        checkOutput("freeze ref accept err", {27'd0, err_a}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            dram_clk_en = !(k >= 2 && k <= 4);
            if (!dram_clk_en)
                applyStimulus(CMD_RD, 3'd0, 7'd0, 2'b00, 2'b00);
            else
                applyStimulus((k <= 7) ? CMD_REF : CMD_NOP, 3'd0, 7'd0, 2'b00, 2'b00);
            checkOutput($sformatf("freeze done edge%0d", k), {31'd0, done_a}, {31'd0, (k == 7)});
        end
        dram_clk_en = 1'b1;
        checkOutput("freeze err_flags", {27'd0, err_a}, 32'd0);
        checkOutput("freeze rd_data", {30'd0, rd_data_a}, 32'd0);
        checkOutput("freeze rd_data cl3", {30'd0, rd_data_b}, 32'd0);

        $display("[TB] asynchronous reset during refresh");
        doReset();
        applyStimulus(CMD_ACT, 3'd1, 7'd5, 2'b00, 2'b00);
        applyStimulus(CMD_WR,  3'd1, 7'd0, 2'b11, 2'b00);
        applyStimulus(CMD_RD,  3'd1, 7'd0, 2'b00, 2'b11);
        applyStimulus(CMD_ILL2, 3'd0, 7'd0, 2'b00, 2'b00);
        applyStimulus(CMD_REF, 3'd0, 7'd0, 2'b00, 2'b00);
        applyStimulus(CMD_REF, 3'd0, 7'd0, 2'b00, 2'b00);
        checkOutput("pre-reset bank_open", {24'd0, open_a}, 32'h02);
        checkOutput("pre-reset err_flags", {27'd0, err_a}, 32'h0C);
        checkOutput("pre-reset rd_data", {30'd0, rd_data_a}, 32'h3);
        #2 u_rst_n = 1'b0;
        sb_a.delete();
        sb_b.delete();
        #1;
        checkOutput("async reset done", {31'd0, done_a}, 32'd0);
        checkOutput("async reset bank_open", {24'd0, open_a}, 32'd0);
        checkOutput("async reset err_flags", {27'd0, err_a}, 32'd0);
        checkOutput("async reset rd_data", {30'd0, rd_data_a}, 32'd0);
        @(negedge u_clk);
        idleBus();
        u_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput($sformatf("post-reset done %0d", k), {31'd0, done_a}, 32'd0);
            checkOutput($sformatf("post-reset rd_data cl3 %0d", k), {30'd0, rd_data_b}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
